invsqrt_pipe_newton: RTL and testbench

- Stage directly downstream of the inverse-square-root init stage. Consumes its x2 (number/2) and y (magic-constant estimate) outputs on a valid pulse.
- Refines y with ITERATIONS Newton-Raphson steps: y <- y*(1.5 - x2*y*y).
- Presents the refined 31-bit positive float (sign bit dropped) with a one-cycle ready pulse.
- Multi-cycle FSM that time-shares one combinational float multiplier.

---
 rtl/invsqrt_pipe_newton_pkg.sv | 23 ++
 rtl/invsqrt_pipe_newton_mul.sv | 34 +++
 rtl/invsqrt_pipe_newton.sv | 138 +++++++++++++
 tb/tb_invsqrt_pipe_newton.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/invsqrt_pipe_newton_pkg.sv
// rtl/invsqrt_pipe_newton_pkg.sv - shared float widths, constants and FSM encoding
package invsqrt_pipe_newton_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int WORD_W = 31;
  localparam int BIAS   = 127;

  // 2 integer bits, 26 fraction bits
  localparam int          FIX_W          = 28;
  localparam logic [27:0] F_ONE_HALF_FIX = 28'h600_0000;

  localparam logic [WORD_W-1:0] FLT_MAX31 = 31'h7F7F_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SQ,
    ST_MX,
    ST_SUB,
    ST_MY
  } state_e;

endpackage

// File: rtl/invsqrt_pipe_newton_mul.sv
// rtl/invsqrt_pipe_newton_mul.sv - combinational positive-float multiply, truncating
module fp_mul31
  import invsqrt_pipe_newton_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  output logic [WORD_W-1:0] p_o
);

  logic [EXP_W-1:0]  ea, eb;
  logic [2*MAN_W+1:0] prod;
  logic signed [9:0] e_sum;
  logic [MAN_W-1:0]  man;

  always_comb begin
    ea    = a_i[WORD_W-1:MAN_W];
    eb    = b_i[WORD_W-1:MAN_W];
    prod  = {1'b1, a_i[MAN_W-1:0]} * {1'b1, b_i[MAN_W-1:0]};
    e_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127
          + $signed({9'b0, prod[47]});
    // product of two [1,2) mantissas lies in [1,4): at most one normalizing shift
    man   = prod[47] ? 23'(prod >> 24) : 23'(prod >> 23);
    if (ea == '0 || eb == '0) begin
      p_o = '0;
    end else if (e_sum <= 10'sd0) begin
      p_o = '0;
    end else if (e_sum >= 10'sd255) begin
      p_o = FLT_MAX31;
    end else begin
      p_o = {e_sum[7:0], man};
    end
  end

endmodule

// File: rtl/invsqrt_pipe_newton.sv
// rtl/invsqrt_pipe_newton.sv - Newton-Raphson refinement of an inverse-sqrt estimate
module invsqrt_pipe_newton
  import invsqrt_pipe_newton_pkg::*;
#(
  parameter int ITERATIONS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [WORD_W-1:0] x2,
  input  logic [WORD_W-1:0] y,
  output logic [WORD_W-1:0] y_out,
  output logic              ready,
  output logic              busy,
  output logic              sat
);

  localparam logic [1:0] ITER_LAST = 2'(ITERATIONS - 1);

  state_e            state_q;
  logic [1:0]        cnt_q;
  logic [WORD_W-1:0] x2_q, y_q, s_q, t_q, f_q, y_out_q;
  logic              ready_q, sat_q, sticky_q;

  logic [WORD_W-1:0] mul_a, mul_b, mul_p;
  logic [EXP_W-1:0]  e_t;
  logic [FIX_W-1:0]  t_fix, diff, norm;
  logic [7:0]        lead;
  logic [WORD_W-1:0] f_d;
  logic              sub_sat;

  always_comb begin
    mul_a = y_q;
    mul_b = y_q;
    case (state_q)
      ST_MX: begin
        mul_a = x2_q;
        mul_b = s_q;
      end
      ST_MY: begin
        mul_a = y_q;
        mul_b = f_q;
      end
      default: ;
    endcase
  end

  fp_mul31 u_mul (
    .a_i(mul_a),
    .b_i(mul_b),
    .p_o(mul_p)
  );

  // f = 1.5 - t in fixed point, then back to float via leading-one search
  always_comb begin
    e_t     = t_q[WORD_W-1:MAN_W];
    sub_sat = 1'b0;
    t_fix   = '0;
    diff    = '0;
    norm    = '0;
    lead    = '0;
    f_d     = '0;
    if (e_t >= 8'd128 || (e_t == 8'd127 && t_q[MAN_W-1:0] >= 23'h40_0000)) begin
      sub_sat = 1'b1;
    end else begin
      if (e_t >= 8'd100) begin
        t_fix = {1'b0, 1'b1, t_q[MAN_W-1:0], 3'b000} >> (8'd127 - e_t);
      end
      diff = F_ONE_HALF_FIX - t_fix;
      for (int i = 0; i < FIX_W; i++) begin
        if (diff[i]) lead = 8'(i);
      end
      norm = diff << (8'd27 - lead);
      f_d  = {8'd101 + lead, 23'(norm >> 4)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      x2_q     <= '0;
      y_q      <= '0;
      s_q      <= '0;
      t_q      <= '0;
      f_q      <= '0;
      y_out_q  <= '0;
      ready_q  <= 1'b0;
      sat_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid) begin
            x2_q     <= x2;
            y_q      <= y;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            state_q  <= ST_SQ;
          end
        end
        ST_SQ: begin
          s_q     <= mul_p;
          state_q <= ST_MX;
        end
        ST_MX: begin
          t_q     <= mul_p;
          state_q <= ST_SUB;
        end
        ST_SUB: begin
          f_q     <= f_d;
          if (sub_sat) sticky_q <= 1'b1;
          state_q <= ST_MY;
        end
        ST_MY: begin
          y_q   <= mul_p;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == ITER_LAST) begin
            y_out_q <= mul_p;
            sat_q   <= sticky_q;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_SQ;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign y_out = y_out_q;
  assign ready = ready_q;
  assign sat   = sat_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_invsqrt_pipe_newton.sv
// tb/tb_invsqrt_pipe_newton.sv - randomized and directed checks against a real-arithmetic model
module tb_invsqrt_pipe_newton;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid1 = 1'b0, valid2 = 1'b0;
  logic [30:0] x2 = '0, y = '0;
  logic [30:0] y_out1, y_out2;
  logic        ready1, ready2, busy1, busy2, sat1, sat2;
  logic        sel = 1'b0;
  logic [30:0] cur_y;
  logic        cur_ready, cur_busy, cur_sat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  invsqrt_pipe_newton #(.ITERATIONS(1)) dut1 (
    .clk(clk), .rst(rst), .valid(valid1), .x2(x2), .y(y),
    .y_out(y_out1), .ready(ready1), .busy(busy1), .sat(sat1)
  );

  invsqrt_pipe_newton #(.ITERATIONS(2)) dut2 (
    .clk(clk), .rst(rst), .valid(valid2), .x2(x2), .y(y),
    .y_out(y_out2), .ready(ready2), .busy(busy2), .sat(sat2)
  );

  assign cur_y     = sel ? y_out2 : y_out1;
  assign cur_ready = sel ? ready2 : ready1;
  assign cur_busy  = sel ? busy2 : busy1;
  assign cur_sat   = sel ? sat2 : sat1;

  function automatic real f2r(input logic [30:0] a);
    logic [63:0] b;
    if (a[30:23] == 8'd0) return 0.0;
    b = {1'b0, 11'(a[30:23]) + 11'd896, a[22:0], 29'b0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [30:0] r2f(input real r);
    logic [63:0] b;
    int e;
    if (r <= 0.0) return '0;
    b = $realtobits(r);
    e = int'(b[62:52]) - 896;
    if (e <= 0) return '0;
    if (e >= 255) return 31'h7F7F_FFFF;
    return {8'(e), b[51:29]};
  endfunction

  function automatic logic [30:0] fmul(input logic [30:0] a, input logic [30:0] b);
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return '0;
    return r2f(f2r(a) * f2r(b));
  endfunction

  task automatic ref_newton(input logic [30:0] xx, input logic [30:0] yy, input int iters,
                            output logic [30:0] yr, output logic sr);
    logic [30:0] s, t, f;
    real tv, tf;
    yr = yy;
    sr = 1'b0;
    for (int k = 0; k < iters; k++) begin
      s  = fmul(yr, yr);
      t  = fmul(xx, s);
      tv = f2r(t);
      if (tv >= 1.5) begin
        f  = '0;
        sr = 1'b1;
      end else begin
        tf = (t[30:23] < 8'd100) ? 0.0 : $floor(tv * 67108864.0);
        f  = r2f(1.5 - tf / 67108864.0);
      end
      yr = fmul(yr, f);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic s, input logic [30:0] xx, input logic [30:0] yy);
    sel = s;
    x2  = xx;
    y   = yy;
    if (s) valid2 = 1'b1; else valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    valid2 = 1'b0;
  endtask

  // called at the negedge of cycle 1; returns at the negedge of the ready cycle
  task automatic wait_check(input logic [30:0] xx, input logic [30:0] yy, input string tag);
    logic [30:0] yr;
    logic        sr;
    int          n, iters;
    iters = sel ? 2 : 1;
    ref_newton(xx, yy, iters, yr, sr);
    check({tag, " busy"}, {31'b0, cur_busy}, 32'd1);
    n = 1;
    while (!cur_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, 4 * iters + 1);
    check({tag, " y_out"}, {1'b0, cur_y}, {1'b0, yr});
    check({tag, " sat"}, {31'b0, cur_sat}, {31'b0, sr});
  endtask

  real err;
  int  pulses;
  logic [30:0] first_y, rx, ry;

  initial begin
    #2;
    check("reset y_out", {1'b0, y_out1}, 32'd0);
    check("reset ready", {31'b0, ready1}, 32'd0);
    check("reset busy", {31'b0, busy1}, 32'd0);
    check("reset sat", {31'b0, sat1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    start(1'b0, 31'h3F80_0000, 31'h3F80_0000);
    wait_check(31'h3F80_0000, 31'h3F80_0000, "one");
    check("one exact", {1'b0, y_out1}, 32'h3F00_0000);
    @(negedge clk);
    check("ready pulse width", {31'b0, ready1}, 32'd0);
    check("y_out held", {1'b0, y_out1}, 32'h3F00_0000);

    start(1'b0, 31'h3F00_0000, 31'h3F80_0000);
    wait_check(31'h3F00_0000, 31'h3F80_0000, "half");
    check("half exact", {1'b0, y_out1}, 32'h3F80_0000);
    start(1'b0, 31'h3F80_0000, 31'h3F80_0000);
    wait_check(31'h3F80_0000, 31'h3F80_0000, "b2b");

    start(1'b0, 31'h4000_0000, 31'h3EF7_59DF);
    wait_check(31'h4000_0000, 31'h3EF7_59DF, "four it1");
    err = f2r(y_out1) - 0.5;
    check("four it1 tol", {31'b0, (err < 0.002 && err > -0.002)}, 32'd1);
    start(1'b1, 31'h4000_0000, 31'h3EF7_59DF);
    wait_check(31'h4000_0000, 31'h3EF7_59DF, "four it2");
    err = f2r(y_out2) - 0.5;
    check("four it2 tol", {31'b0, (err < 0.00001 && err > -0.00001)}, 32'd1);

    start(1'b0, 31'h4000_0000, 31'h3F80_0000);
    wait_check(31'h4000_0000, 31'h3F80_0000, "satur");
    check("satur y", {1'b0, y_out1}, 32'd0);
    check("satur sat", {31'b0, sat1}, 32'd1);
    start(1'b0, 31'h3F80_0000, 31'h0000_0000);
    wait_check(31'h3F80_0000, 31'h0000_0000, "zero y");
    check("zero sat", {31'b0, sat1}, 32'd0);
    start(1'b1, 31'h4000_0000, 31'h3F80_0000);
    wait_check(31'h4000_0000, 31'h3F80_0000, "satur it2");

    for (int i = 0; i < 24; i++) begin
      rx = {8'($urandom_range(100, 150)), 23'($urandom)};
      ry = {8'($urandom_range(100, 150)), 23'($urandom)};
      start(1'(i % 2), rx, ry);
      wait_check(rx, ry, $sformatf("rand%0d", i));
    end

    // operand strobes while busy are dropped
    sel = 1'b0;
    x2 = 31'h3F00_0000;
    y  = 31'h3F80_0000;
    valid1 = 1'b1;
    pulses = 0;
    first_y = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c <= 4) check($sformatf("spam busy c%0d", c), {31'b0, busy1}, 32'd1);
      if (ready1) begin
        pulses++;
        first_y = y_out1;
      end
      valid1 = (c <= 4);
      x2 = {8'($urandom_range(110, 140)), 23'($urandom)};
      y  = {8'($urandom_range(110, 140)), 23'($urandom)};
    end
    valid1 = 1'b0;
    check("spam pulses", pulses, 1);
    check("spam result", {1'b0, first_y}, 32'h3F80_0000);

    // asynchronous reset in the MX cycle
    start(1'b0, 31'h3F80_0000, 31'h3F80_0000);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst y_out", {1'b0, y_out1}, 32'd0);
    check("rst busy", {31'b0, busy1}, 32'd0);
    check("rst ready", {31'b0, ready1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ready1) pulses++;
    end
    check("rst no pulse", pulses, 0);
    start(1'b0, 31'h3F00_0000, 31'h3F80_0000);
    wait_check(31'h3F00_0000, 31'h3F80_0000, "post rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
